// File: rtl/conv2_sched.sv
// Frame sequencer for conv2: raster-reads the conv1 feature map, feeds the window buffer and
// tags buffer outputs as legal/illegal 3x3 windows. Optional CONV2_SCHED_PERF_EN adds stall_cycles.
module conv2_sched #(
    parameter int WIDTH   = 13,
    parameter int HEIGHT  = 13,
    parameter int ADDR_W  = 8,
    parameter int BUF_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              buf_valid_in,
    output logic [7:0]        buf_pixel_in,
    input  logic              buf_valid_out,
    output logic              win_valid,
    output logic [3:0]        win_row,
    output logic [3:0]        win_col
`ifdef CONV2_SCHED_PERF_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int DW = $clog2(BUF_LAT + 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              start_ok, rd_go, tag_in;
    logic              push_q;
    logic [7:0]        pixel_q;
    logic [RW-1:0]     pr_q;
    logic [CW-1:0]     pc_q;
    logic [BUF_LAT-1:0] tag_q;
    logic [BUF_LAT:0]  tag_ext;
    logic [3:0]        wr_q, wc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            drain_q  <= drain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        drain_d  = drain_q;
        start_ok = 1'b0;
        rd_go    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    rd_ptr_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    rd_go    = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (rd_ptr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            // Hold until the final push has cleared the tag pipeline.
            S_DRAIN: begin
                if (drain_q == DW'(BUF_LAT)) state_d = S_DONE;
                else                         drain_d = drain_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign mem_rd_en = rd_go;
    assign mem_addr  = rd_ptr_q;

    // The pushed pixel is the bottom-right corner of its window.
    assign tag_in  = push_q && (pr_q >= RW'(2)) && (pc_q >= CW'(2));
    assign tag_ext = {tag_q, tag_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_q  <= 1'b0;
            pixel_q <= '0;
            pr_q    <= '0;
            pc_q    <= '0;
            tag_q   <= '0;
        end else begin
            push_q  <= rd_go;
            pixel_q <= mem_rd_data;
            tag_q   <= tag_ext[BUF_LAT-1:0];
            if (start_ok) begin
                pr_q <= '0;
                pc_q <= '0;
            end else if (push_q) begin
                if (pc_q == CW'(WIDTH - 1)) begin
                    pc_q <= '0;
                    pr_q <= pr_q + 1'b1;
                end else begin
                    pc_q <= pc_q + 1'b1;
                end
            end
        end
    end

    assign buf_valid_in = push_q;
    assign buf_pixel_in = pixel_q;
    assign win_valid    = buf_valid_out && tag_q[BUF_LAT-1];
    assign win_row      = wr_q;
    assign win_col      = wc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            wc_q <= '0;
        end else if (start_ok) begin
            wr_q <= '0;
            wc_q <= '0;
        end else if (win_valid) begin
            if (wc_q == 4'(WIDTH - 3)) begin
                wc_q <= '0;
                wr_q <= (wr_q == 4'(HEIGHT - 3)) ? 4'd0 : wr_q + 4'd1;
            end else begin
                wc_q <= wc_q + 4'd1;
            end
        end
    end

`ifdef CONV2_SCHED_PERF_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        stall_cnt_q <= '0;
        else if (start_ok)                                 stall_cnt_q <= '0;
        else if (busy && stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule
